// File: rtl/enemy_spawner_if.sv
// Game-side bundle for the enemy spawner: run/hit in, per-slot control and status out.
interface enemy_spawner_if #(
    parameter int unsigned N_ENEMIES = 4
);
    logic                    run;
    logic [N_ENEMIES-1:0]    hit;
    logic [16*N_ENEMIES-1:0] control;
    logic [N_ENEMIES-1:0]    en;
    logic [N_ENEMIES-1:0]    enemy_rst;
    logic [1:0]              level;
    logic [7:0]              kills;

    // Game logic side: drives run and hit, observes the spawner.
    modport master (
        output run, hit,
        input  control, en, enemy_rst, level, kills
    );

    // Spawner side.
    modport slave (
        input  run, hit,
        output control, en, enemy_rst, level, kills
    );
endinterface

// File: rtl/enemy_spawner.sv
// Frame-rate enemy scheduler: owns N_ENEMIES slots, releases one enemy per level-dependent
// interval into the lowest free slot, frees slots on hits, and tracks kills and difficulty.
module enemy_spawner #(
    parameter int unsigned   N_ENEMIES       = 4,
    parameter logic [7:0]    BASE_INTERVAL   = 8'd90,
    parameter logic [7:0]    INTERVAL_STEP   = 8'd20,
    parameter int unsigned   KILLS_PER_LEVEL = 8,
    parameter logic [15:0]   LFSR_SEED       = 16'hACE1
) (
    input logic            frame_clk,
    input logic            rst_n,
    enemy_spawner_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StSpawn,
        StFull
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [16*N_ENEMIES-1:0] control_q, control_d;
    logic [N_ENEMIES-1:0]    en_q, en_d;
    logic [N_ENEMIES-1:0]    enemy_rst_q, enemy_rst_d;
    // Slots whose enemy_rst is high only because of last edge's hit pulse.
    logic [N_ENEMIES-1:0]    rst_pulse_q, rst_pulse_d;
    logic [7:0]              kills_q, kills_d;
    logic [1:0]              level_q, level_d;

    logic [N_ENEMIES-1:0]    valid_hit;
    logic [N_ENEMIES-1:0]    free;
    logic [N_ENEMIES-1:0]    spawn_sel;
    logic                    any_free;
    logic [7:0]              interval;
    logic [3:0]              hit_cnt;
    logic [8:0]              kill_sum;
    logic [31:0]             lvl_div;

    // Galois LFSR, frozen while the game is parked.
    always_comb begin
        lfsr_d = lfsr_q;
        if (bus.run) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Per-slot control words: randomised position/direction plus the current level as speed.
    always_comb begin
        control_d = control_q;
        if (bus.run) begin
            for (int k = 0; k < int'(N_ENEMIES); k++) begin
                control_d[16*k +: 16] = {3'b000, level_q, lfsr_q[15] ^ ((k % 2) == 1),
                                         lfsr_q[9:0] ^ 10'(k * 97)};
            end
        end
    end

    // Hit qualification, free-slot search and kill/level bookkeeping.
    always_comb begin
        valid_hit = (state_q != StIdle && bus.run) ? (bus.hit & en_q) : '0;
        // A hit on a slot blocks it this edge even when it is not counted.
        free      = ~en_q & ~bus.hit;
        spawn_sel = '0;
        any_free  = 1'b0;
        for (int k = 0; k < int'(N_ENEMIES); k++) begin
            if (free[k] && !any_free) begin
                spawn_sel[k] = 1'b1;
                any_free     = 1'b1;
            end
        end
        hit_cnt = 4'd0;
        for (int k = 0; k < int'(N_ENEMIES); k++) begin
            hit_cnt = hit_cnt + {3'd0, valid_hit[k]};
        end
        kill_sum = {1'b0, kills_q} + {5'd0, hit_cnt};
        kills_d  = kill_sum[8] ? 8'hFF : kill_sum[7:0];
        lvl_div  = {24'd0, kills_d} / KILLS_PER_LEVEL;
        level_d  = (lvl_div > 32'd3) ? 2'd3 : lvl_div[1:0];
        interval = BASE_INTERVAL - INTERVAL_STEP * {6'd0, level_q};
    end

    // Spawn FSM next-state and slot enable/reset outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        en_d        = en_q & ~valid_hit;
        enemy_rst_d = (enemy_rst_q & ~rst_pulse_q) | valid_hit;
        rst_pulse_d = valid_hit;
        if (!bus.run) begin
            state_d     = StIdle;
            en_d        = '0;
            enemy_rst_d = '1;
            rst_pulse_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    en_d        = '0;
                    enemy_rst_d = '1;
                    rst_pulse_d = '0;
                    cnt_d       = interval;
                    state_d     = StCount;
                end
                StCount: begin
                    cnt_d = cnt_q - 8'd1;
                    // Leaving on the 1->0 step puts the spawn exactly interval+1 edges apart.
                    if (cnt_q <= 8'd1) begin
                        state_d = StSpawn;
                    end
                end
                StSpawn: begin
                    if (any_free) begin
                        en_d        = en_d | spawn_sel;
                        enemy_rst_d = enemy_rst_d & ~spawn_sel;
                        cnt_d       = interval;
                        state_d     = StCount;
                    end else begin
                        state_d = StFull;
                    end
                end
                StFull: begin
                    // A freed slot restarts the full interval rather than spawning at once.
                    if (any_free) begin
                        cnt_d   = interval;
                        state_d = StCount;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge frame_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            lfsr_q      <= LFSR_SEED;
            control_q   <= '0;
            en_q        <= '0;
            enemy_rst_q <= '1;
            rst_pulse_q <= '0;
            kills_q     <= 8'd0;
            level_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            control_q   <= control_d;
            en_q        <= en_d;
            enemy_rst_q <= enemy_rst_d;
            rst_pulse_q <= rst_pulse_d;
            kills_q     <= kills_d;
            level_q     <= level_d;
        end
    end

    assign bus.control   = control_q;
    assign bus.en        = en_q;
    assign bus.enemy_rst = enemy_rst_q;
    assign bus.kills     = kills_q;
    assign bus.level     = level_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Scoreboard bench for enemy_spawner: stimulus pushes expected output changes and control
// samples; a monitor pops and compares whenever the registered outputs change.
module tb_enemy_spawner;

    localparam logic [15:0] SEED = 16'hACE1;

    logic frame_clk;
    logic rst_n;
    int   edge_no = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   tag_no  = 0;

    enemy_spawner_if #(.N_ENEMIES(4)) bus ();

    enemy_spawner #(
        .N_ENEMIES      (4),
        .BASE_INTERVAL  (8'd90),
        .INTERVAL_STEP  (8'd20),
        .KILLS_PER_LEVEL(8),
        .LFSR_SEED      (SEED)
    ) dut (
        .frame_clk(frame_clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    typedef struct {
        int         tag;
        int         at;
        logic [3:0] en;
        logic [3:0] rst;
        logic [7:0] kills;
        logic [1:0] level;
    } ev_t;

    typedef struct {
        int          at;
        int          slot;
        logic [15:0] word;
    } ctl_t;

    ev_t  ev_q[$];
    ctl_t ctl_q[$];

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Edges counted only while out of reset; edge 1 is the first edge after release.
    always @(posedge frame_clk) if (rst_n) edge_no <= edge_no + 1;

    function automatic logic [1:0] lvl_of(input int k);
        return (k / 8 >= 3) ? 2'd3 : 2'(k / 8);
    endfunction

    function automatic int interval_of(input int k);
        return 90 - 20 * int'(lvl_of(k));
    endfunction

    function automatic logic [15:0] lfsr_adv(input int n);
        logic [15:0] l;
        l = SEED;
        for (int i = 0; i < n; i++) l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        return l;
    endfunction

    function automatic logic [15:0] ctrl_word(input int k, input logic [15:0] l,
                                              input logic [1:0] v);
        logic [9:0] mix;
        logic       lsb;
        mix = 10'(k * 97);
        lsb = (k % 2) == 1;
        return {3'b000, v, l[15] ^ lsb, l[9:0] ^ mix};
    endfunction

    task automatic push_ev(input int at, input logic [3:0] en, input logic [3:0] rst,
                           input int kills, input logic [1:0] level);
        ev_t e;
        e.tag   = tag_no;
        e.at    = at;
        e.en    = en;
        e.rst   = rst;
        e.kills = 8'(kills);
        e.level = level;
        tag_no++;
        ev_q.push_back(e);
    endtask

    task automatic push_ctl(input int at, input int slot, input logic [15:0] word);
        ctl_t c;
        c.at   = at;
        c.slot = slot;
        c.word = word;
        ctl_q.push_back(c);
    endtask

    task automatic wait_until(input int e);
        while (edge_no < e) @(negedge frame_clk);
    endtask

    // Hold hit across exactly edge 'at'.
    task automatic drive_hit(input int at, input logic [3:0] h);
        wait_until(at - 1);
        bus.hit = h;
        @(negedge frame_clk);
        bus.hit = 4'h0;
    endtask

    // Monitor: any change of the status outputs consumes one expected event.
    initial begin
        logic [17:0] prev;
        logic [17:0] cur;
        logic [17:0] want;
        logic [15:0] got;
        ev_t         e;
        ctl_t        c;
        prev = '0;
        forever begin
            @(negedge frame_clk or negedge rst_n);
            #1;
            cur = {bus.en, bus.enemy_rst, bus.kills, bus.level};
            if (cur !== prev) begin
                checks++;
                if (ev_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change edge %0d: en=%b rst=%b kills=%0d level=%0d",
                             edge_no, bus.en, bus.enemy_rst, bus.kills, bus.level);
                end else begin
                    e    = ev_q.pop_front();
                    want = {e.en, e.rst, e.kills, e.level};
                    if (e.at != edge_no || cur !== want) begin
                        errors++;
                        $display({"FAIL event%0d: got edge %0d en=%b rst=%b kills=%0d lvl=%0d,",
                                  " want edge %0d en=%b rst=%b kills=%0d lvl=%0d"},
                                 e.tag, edge_no, bus.en, bus.enemy_rst, bus.kills, bus.level,
                                 e.at, e.en, e.rst, e.kills, e.level);
                    end
                end
                prev = cur;
            end
            while (ctl_q.size() > 0 && ctl_q[0].at <= edge_no) begin
                c   = ctl_q.pop_front();
                got = bus.control[16*c.slot +: 16];
                checks++;
                if (c.at != edge_no || got !== c.word) begin
                    errors++;
                    $display("FAIL control[%0d]@%0d: got %h at edge %0d, want %h",
                             c.slot, c.at, got, edge_no, c.word);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int e0;
        int s;
        int h;
        int k_now;
        int k_next;
        int sat;
        int last_s;
        int a;
        int b;
        logic [1:0] lv;

        bus.run = 1'b0;
        bus.hit = 4'h0;
        rst_n   = 1'b1;
        push_ev(0, 4'h0, 4'hF, 0, 2'd0);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge frame_clk);
        rst_n = 1'b1;
        repeat (10) @(negedge frame_clk);

        // First spawns: run sampled at e0, spawns every 91 edges into slots 0..3.
        bus.run = 1'b1;
        e0      = edge_no + 1;
        for (int k = 0; k < 4; k++) push_ctl(e0, k, ctrl_word(k, SEED, 2'd0));
        push_ev(e0 + 91,  4'b0001, 4'b1110, 0, 2'd0);
        for (int k = 0; k < 4; k++) push_ctl(e0 + 91, k, ctrl_word(k, lfsr_adv(91), 2'd0));
        push_ev(e0 + 182, 4'b0011, 4'b1100, 0, 2'd0);
        push_ev(e0 + 273, 4'b0111, 4'b1000, 0, 2'd0);
        push_ev(e0 + 364, 4'b1111, 4'b0000, 0, 2'd0);

        // Pool full: nothing happens for 300 edges, then hit slot 2.
        h = e0 + 364 + 301;
        push_ev(h,     4'b1011, 4'b0100, 1, 2'd0);
        push_ev(h + 1, 4'b1011, 4'b0000, 1, 2'd0);
        // One FULL edge to see the freed slot, then a full 91-edge interval.
        push_ev(h + 92, 4'b1111, 4'b0000, 1, 2'd0);
        drive_hit(h, 4'b0100);
        s = h + 92;

        // Simultaneous hits, an ignored hit, then a hit blocking the slot a spawn would take.
        push_ev(s + 2, 4'b1010, 4'b0101, 3, 2'd0);
        push_ev(s + 3, 4'b1010, 4'b0000, 3, 2'd0);
        push_ev(s + 5, 4'b0000, 4'b1010, 5, 2'd0);
        push_ev(s + 6, 4'b0000, 4'b0000, 5, 2'd0);
        push_ev(s + 91, 4'b0010, 4'b0000, 5, 2'd0);
        drive_hit(s + 2, 4'b0101);
        drive_hit(s + 4, 4'b0101);
        drive_hit(s + 5, 4'b1010);
        drive_hit(s + 91, 4'b0001);
        s = s + 91;
        push_ev(s + 1, 4'b0000, 4'b0010, 6, 2'd0);
        push_ev(s + 2, 4'b0000, 4'b0000, 6, 2'd0);
        drive_hit(s + 1, 4'b0010);
        s = s + 91;

        // Level ramp to saturation: spawn into slot 0, kill it on the next edge.
        k_now  = 6;
        sat    = 0;
        last_s = s;
        while (sat < 2) begin
            if (k_now == 255) sat++;
            lv     = lvl_of(k_now);
            k_next = (k_now < 255) ? k_now + 1 : 255;
            push_ev(s, 4'b0001, 4'b0000, k_now, lv);
            push_ctl(s, k_now % 4, ctrl_word(k_now % 4, lfsr_adv(s - e0), lv));
            push_ev(s + 1, 4'b0000, 4'b0001, k_next, lvl_of(k_next));
            push_ev(s + 2, 4'b0000, 4'b0000, k_next, lvl_of(k_next));
            drive_hit(s + 1, 4'b0001);
            last_s = s;
            s      = s + interval_of(k_now) + 1;
            k_now  = k_next;
        end

        // Abort mid-count: everything parks, LFSR and control freeze, kills/level stay.
        wait_until(last_s + 5);
        bus.run = 1'b0;
        a       = edge_no + 1;
        push_ev(a, 4'b0000, 4'b1111, 255, 2'd3);
        push_ctl(a + 3, 0, ctrl_word(0, lfsr_adv(a - 1 - e0), 2'd3));
        wait_until(a + 9);
        bus.run = 1'b1;
        b       = edge_no + 1;
        push_ctl(b, 0, ctrl_word(0, lfsr_adv(a - e0), 2'd3));
        push_ev(b + 31, 4'b0001, 4'b1110, 255, 2'd3);

        // Asynchronous reset between edges.
        wait_until(b + 33);
        #2;
        push_ev(edge_no, 4'b0000, 4'b1111, 0, 2'd0);
        push_ctl(edge_no, 0, 16'h0000);
        rst_n = 1'b0;
        repeat (4) @(negedge frame_clk);
        #3;

        while (ev_q.size() > 0) begin
            ev_t e;
            e = ev_q.pop_front();
            checks++;
            errors++;
            $display("FAIL event%0d: got no change, want edge %0d en=%b rst=%b kills=%0d",
                     e.tag, e.at, e.en, e.rst, e.kills);
        end
        while (ctl_q.size() > 0) begin
            ctl_t c;
            c = ctl_q.pop_front();
            checks++;
            errors++;
            $display("FAIL control[%0d]@%0d: got no sample, want %h", c.slot, c.at, c.word);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enemy_spawner.md
# enemy_spawner

Frame-rate scheduler directly upstream of the enemy sprite instances. It owns a pool of N_ENEMIES slots and drives each instance's 16-bit `control` word, `en` and reset. It releases a new enemy on a level-dependent interval and frees a slot when that enemy is hit. It also tracks kills and difficulty level, and folds the level into the speed bits of `control`.

## Interface
- N_ENEMIES, 4: number of enemy slots (1..8)
- BASE_INTERVAL, 90: frames between spawns at level 0 (8-bit)
- INTERVAL_STEP, 20: interval reduction per level; BASE_INTERVAL - 3*INTERVAL_STEP must be >= 1
- KILLS_PER_LEVEL, 8: kills needed per level increment
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero

Ports:
- frame_clk  in  1  the only clock; one edge per video frame
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  game active; low parks all enemies
- hit  in  N_ENEMIES  per-slot destroyed pulse, one frame wide
- control  out  16*N_ENEMIES  slot k occupies bits [16k+15:16k]
- en  out  N_ENEMIES  per-slot motion enable
- enemy_rst  out  N_ENEMIES  per-slot active-high reset to the enemy instance
- level  out  2  difficulty level 0..3
- kills  out  8  saturating kill counter

## Operation
- LFSR: 16-bit Galois, mask 16'hB400, shift right, advances every frame_clk edge while run=1. It holds while run=0.
- control[k] is registered and refreshed every edge while run=1:
  - [9:0] = lfsr[9:0] XOR (k*10'd97)
  - [10] = lfsr[15] XOR k[0]
  - [12:11] = level
  - [15:13] = 0
- Enemy instances sample `control` at their own respawn, so each respawn sees fresh values.
- level = min(kills / KILLS_PER_LEVEL, 3).
- interval = BASE_INTERVAL - level*INTERVAL_STEP. Computed in 8 bits; the parameter rule guarantees no underflow.
- Free slot: en[k]=0 and hit[k]=0 this edge. The selected free slot is the lowest-index free slot.
- FSM states:
  - IDLE: en=0 and enemy_rst=all ones. On run=1, load the countdown with interval and go to COUNT.
  - COUNT: decrement the countdown each edge. When it reaches 0, go to SPAWN.
  - SPAWN (one edge): if a free slot exists, set en[slot], clear enemy_rst[slot], reload the countdown, and go to COUNT. Otherwise go to FULL.
  - FULL: when any free slot exists, reload the countdown and go to COUNT. The interval after a kill is never skipped.
  - From any state, run=0 sends the FSM to IDLE on the next edge.
- Hit handling (any state except IDLE):
  - hit[k] with en[k]=1 clears en[k] and pulses enemy_rst[k] for exactly one edge.
  - The same edge increments kills, saturating at 255.
  - hit[k] with en[k]=0 is ignored and does not count.
  - Multiple simultaneous hits each count; kills += popcount, saturating.
- After the enemy_rst pulse, enemy_rst[k] returns to 0. The instance sits at its start position until en[k] is set again, then respawns using the current control[k].

## Timing
- All outputs are registered on frame_clk.
- Reset values:
  - state IDLE
  - lfsr = LFSR_SEED
  - control = 0
  - en = 0
  - enemy_rst = all ones
  - kills = 0
  - level = 0
- First spawn: run rises before edge e0. Then IDLE→COUNT at e0, and en[0] rises at edge e0+interval+1.
- Spawn period in steady state: interval+1 edges (COUNT drains interval edges, plus one SPAWN edge).
- Hit latency: hit[k] high before edge n makes en[k]=0, enemy_rst[k]=1, and kills updated after edge n. enemy_rst[k]=0 after edge n+1.
- A hit and a spawn on the same edge for the same slot: the hit wins. That slot is not free this edge, so spawn picks another slot or goes to FULL.
- Level change takes effect on the next countdown reload. A countdown already in progress is not shortened.
- rst_n assertion mid-operation immediately forces all reset values, with no wait for an edge.
- run=0 leaves kills and level unchanged; only rst_n clears them.

## Test plan
- Reset/idle: hold rst_n=0, then release with run=0 for 10 edges -> en=0, enemy_rst=4'hF, control=0, lfsr stays 16'hACE1.
- First spawn: raise run -> en=4'b0001 exactly 91 edges after run is sampled, next 4'b0011 91 edges later. control[0][12:11]=0, control[0][15:13]=0.
- Fill and FULL: run until en=4'hF, then wait 300 edges -> no change. Pulse hit[2] -> en=4'b1011, enemy_rst=4'b0100 for one edge, kills=1. en[2] re-set 91 edges later.
- Level ramp: deliver 8 valid hits -> level=1, the next reload uses 70, and control[k][12:11]=2'b01. After 24 kills, level=3, interval=30 and stays there. kills saturates at 255.
- Invalid/simultaneous hits: hit on a slot with en=0 -> kills unchanged. hit=4'b0101 with both slots enabled -> kills += 2. A hit on the slot chosen in the same SPAWN edge -> that slot stays 0 and the next free slot is taken.
- Mid-run abort: drop run during COUNT -> next edge en=0, enemy_rst=4'hF, and the LFSR freezes. Assert rst_n=0 asynchronously mid-frame -> outputs return to reset values without waiting for an edge.
